ps2_receiver: RTL and testbench



---
 rtl/ps2_receiver.sv | 193 +++++++++++++++++++
 tb/tb_ps2_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// ps2_receiver
//   Deserialises a PS/2 keyboard line into 8-bit scan codes. Each frame is
//   start(0), D0..D7 LSB first, odd parity, stop(1). Data is sampled on every
//   falling edge of the synchronised PS/2 clock.
//   A good frame updates scan_code and pulses scan_valid for one cycle.
//   A parity, stop or timeout failure pulses frame_error for one cycle.
//   A frame that stalls for TIMEOUT_CYCLES clocks between falling edges is
//   abandoned, so a stray edge cannot wedge the receiver.
//
// Optional feature:
//   PS2_GLITCH_FILTER_EN - when defined, the synchronised PS/2 clock passes
//   through a FILTER_LEN-sample stability filter before edge detection.
//   Clock pulses shorter than FILTER_LEN cycles are ignored, and latency grows
//   by FILTER_LEN cycles. When undefined, edges are detected on the synchroniser
//   output directly.
//
// Parameters:
//   TIMEOUT_CYCLES - clocks allowed between falling edges inside a frame
//   FILTER_LEN     - stable-sample count of the optional glitch filter
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   scan_code    last good byte, held until the next good frame
//   scan_valid   one-cycle pulse when scan_code updates
//   frame_error  one-cycle pulse on parity, stop or timeout failure
//   busy         high while a frame is in progress
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Elaboration-time guard against nonsensical configurations.
  if (TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_bad_params
    $error("ps2_receiver: TIMEOUT_CYCLES must be >= 2 and FILTER_LEN >= 1");
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers; they reset to 1 because an idle PS/2 line is high.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;

  // NOTE: every clocked assignment uses <= so all flops update from the values
  // they held before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // ---------------------------------------------------------------------------
  // Clock used for edge detection: filtered or direct.
  // ---------------------------------------------------------------------------
  logic clk_edge_src;

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] filt_cnt;
  logic          clk_filt;

  // The filtered clock follows clk_s only after FILTER_LEN consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign clk_edge_src = clk_filt;
`else
  assign clk_edge_src = clk_s;
`endif

  logic clk_prev;
  logic fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_edge_src;
  end

  assign fall = clk_prev & ~clk_edge_src;

  // ---------------------------------------------------------------------------
  // Frame FSM, shift register, timeout.
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] timeout_cnt;

  // NOTE: all datapath registers are reset (not only the FSM) so that scan_code
  // and the frame buffer have defined values from the first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      timeout_cnt <= '0;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (fall) begin
        // A fall always wins over a coinciding terminal count.
        timeout_cnt <= '0;
        case (state)
          IDLE: begin
            // A high data bit here is a spurious edge and is ignored.
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;  // wraps back to 0 after the 8th bit
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s;
            state      <= STOP;
          end
          default: begin  // STOP
            if (data_s && (^{shift_reg, parity_bit})) begin
              scan_code  <= shift_reg;
              scan_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (timeout_cnt == TIMEOUT_LAST) begin
          state       <= IDLE;
          frame_error <= 1'b1;
          shift_reg   <= '0;
          bit_cnt     <= '0;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + TW'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver
//   Directed and randomised PS/2 frames against ps2_receiver. A behavioural
//   model turns the sequence of sampled falling-edge data bits into expected
//   scan-code / error events; a monitor matches every DUT strobe against them.
module tb_ps2_receiver;

  localparam int TIMEOUT = 200;
  localparam int FLEN    = 8;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int FILT_DLY = FLEN;
`else
  localparam int FILT_DLY = 0;
`endif
  // Cycles from driving ps2_clk low to the strobe being visible.
  localparam int FALL_TO_PULSE = 3 + FILT_DLY;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;
  logic       busy;

  ps2_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (FLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: collects the data bit seen at each falling edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       err;
    logic [7:0] code;
  } ev_t;

  ev_t        exp_q[$];
  logic       frame_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic push_ev(input logic err, input logic [7:0] code);
    ev_t e;
    e.err  = err;
    e.code = code;
    exp_q.push_back(e);
    if (!err) last_good = code;
  endtask

  task automatic model_fall(input logic b);
    logic [7:0] d;
    int         ones;
    if (frame_q.size() == 0 && b) return;  // idle line, not a start bit
    frame_q.push_back(b);
    if (frame_q.size() == 11) begin
      for (int i = 0; i < 8; i++) d[i] = frame_q[i + 1];
      ones = $countones(d) + int'(frame_q[9]);
      if (frame_q[10] && (ones % 2 == 1)) push_ev(1'b0, d);
      else                                push_ev(1'b1, 8'h00);
      frame_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every strobe must match the next expected event.
  // ---------------------------------------------------------------------------
  int last_evt_cyc  = 0;
  int last_fall_cyc = 0;

  always @(negedge clk) begin
    if (scan_valid || frame_error) begin
      last_evt_cyc <= cyc;
      check("strobe_exclusive", {31'd0, scan_valid & frame_error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, scan_valid, frame_error}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, frame_error}, {31'd0, e.err});
        if (!e.err) check("strobe_code", {24'd0, scan_code}, {24'd0, e.code});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PS/2 line driver.
  // ---------------------------------------------------------------------------
  int half = 40;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      tick(half / 3);
      ps2_clk = 1'b0;  // 3-cycle low glitch in the high phase
`ifndef PS2_GLITCH_FILTER_EN
      model_fall(b);
`endif
      tick(3);
      ps2_clk = 1'b1;
      tick(half - half / 3 - 3);
    end else begin
      tick(half);
    end
    ps2_clk       = 1'b0;
    last_fall_cyc = cyc;
    model_fall(b);
    tick(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par,
                            input logic flip_stop, input logic [10:0] glitch_mask);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[9]   = ~(^d) ^ flip_par;
    bits[10]  = ~flip_stop;
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch_mask[i]);
    ps2_data = 1'b1;
    tick(half);
  endtask

  // Idle long enough for any partial frame to time out.
  task automatic flush();
    if (frame_q.size() != 0) begin
      push_ev(1'b1, 8'h00);
      frame_q.delete();
    end
    tick(TIMEOUT + 60);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: cycle budget exceeded");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       fp;
    logic       fs;

    // Reset state.
    reset = 1'b1;
    tick(3);
    check("reset_scan_code", {24'd0, scan_code}, 32'h00);
    check("reset_scan_valid", {31'd0, scan_valid}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(5);

    // Single good frame and its strobe latency.
    half = 40;
    send_frame(8'h1C, 1'b0, 1'b0, 11'd0);
    check("latency_valid", last_evt_cyc - last_fall_cyc, FALL_TO_PULSE);
    check("code_1c", {24'd0, scan_code}, 32'h1C);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // Break byte followed by a make code.
    send_frame(8'hF0, 1'b0, 1'b0, 11'd0);
    check("code_f0", {24'd0, scan_code}, 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 11'd0);
    check("code_1c_after_f0", {24'd0, scan_code}, 32'h1C);

    // Parity error keeps the previous byte.
    send_frame(8'h1C, 1'b1, 1'b0, 11'd0);
    check("hold_after_parity_err", {24'd0, scan_code}, {24'd0, last_good});

    // Stop error, then recovery.
    send_frame(8'h1C, 1'b0, 1'b1, 11'd0);
    check("hold_after_stop_err", {24'd0, scan_code}, {24'd0, last_good});
    send_frame(8'h5A, 1'b0, 1'b0, 11'd0);
    check("code_5a", {24'd0, scan_code}, 32'h5A);

    // Stalled frame: start + 4 data bits, then idle.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    flush();
    check("latency_timeout", last_evt_cyc - last_fall_cyc, TIMEOUT + FALL_TO_PULSE);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0, 11'd0);
    check("code_1c_after_timeout", {24'd0, scan_code}, 32'h1C);

    // Reset in the middle of a frame.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    frame_q.delete();
    last_good = 8'h00;
    tick(4);
    check("midframe_reset_code", {24'd0, scan_code}, 32'h00);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(5);
    send_frame(8'h29, 1'b0, 1'b0, 11'd0);
    check("code_29", {24'd0, scan_code}, 32'h29);

    // Short clock glitches during the high phase of bits 3 and 7.
    send_frame(8'h1C, 1'b0, 1'b0, 11'b000_1000_1000);
    flush();
    check("glitch_frame_code", {24'd0, scan_code}, {24'd0, last_good});

    // Randomised frames, occasionally corrupted.
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      fp   = ($urandom_range(0, 3) == 0);
      fs   = ($urandom_range(0, 3) == 0);
      half = $urandom_range(20, 60);
      send_frame(d, fp, fs, 11'd0);
      check("random_code", {24'd0, scan_code}, {24'd0, last_good});
      tick($urandom_range(1, 50));
    end

    tick(20);
    check("pending_events", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
